// File: rtl/preif_pcgen.sv
// Pre-IF stage: selects the next fetch PC, translates it through TLB port 0,
// issues I-cache requests and marks responses that belong to squashed fetches.
module preif_pcgen #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter logic [31:0] REFILL_VEC      = 32'hbfc00200,
  parameter logic [31:0] EXC_VEC         = 32'hbfc00380,
  parameter int          FETCH_WIDTH     = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fs_allowin,
  output logic                    prefs_to_fs_valid,
  output logic [34+FETCH_WIDTH:0] prefs_to_fs_bus,
  input  logic                    bp_redirect,
  input  logic [31:0]             bp_target,
  input  logic                    flush_exc,
  input  logic                    flush_refill,
  input  logic                    flush_eret,
  input  logic [31:0]             cp0_epc,
  input  logic                    flush_pipe,
  input  logic [31:0]             flush_pc,
  output logic                    icache_req,
  output logic [1:0]              icache_size,
  output logic [31:0]             icache_addr,
  input  logic                    icache_addr_ok,
  input  logic                    icache_data_ok,
  output logic                    resp_discard,
  output logic [18:0]             s0_vpn2,
  output logic                    s0_odd_page,
  input  logic                    s0_found,
  input  logic [19:0]             s0_pfn,
  input  logic                    s0_v
);

  localparam int          FB        = 4 * FETCH_WIDTH;
  localparam int          LOG_FB    = $clog2(FB);
  localparam logic [31:0] FB_MASK   = ~(32'(FB) - 32'd1);
  localparam logic [31:0] FB_INC    = 32'(FB);
  localparam logic [4:0]  MAX_TOTAL = 5'(MAX_OUTSTANDING);

  logic [31:0] pc_q, pc_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic [3:0]  drop_cnt_q, drop_cnt_d;
  logic        halted_q, halted_d;

  logic [31:0] redir_target;
  logic        redir;
  logic [31:0] fetch_pc;
  logic [31:0] pa;
  logic [31:0] seq_pc;
  logic        mapped;
  logic        adel;
  logic        tlb_refill;
  logic        tlb_invalid;
  logic        exc;
  logic [FETCH_WIDTH-1:0] slot_mask;
  logic [4:0]  total;
  logic        go;
  logic        accept;
  logic        exc_pass;
  logic        drop_nz;
  logic        stale_ret;
  logic        live_ret;

  always_comb begin
    redir_target = bp_target;
    if (flush_exc && flush_refill) begin
      redir_target = REFILL_VEC;
    end else if (flush_exc) begin
      redir_target = EXC_VEC;
    end else if (flush_eret) begin
      redir_target = cp0_epc;
    end else if (flush_pipe) begin
      redir_target = flush_pc;
    end
  end

  // flush_refill only qualifies flush_exc, so it is not a redirect on its own
  assign redir    = flush_exc | flush_eret | flush_pipe | bp_redirect;
  assign fetch_pc = redir ? redir_target : pc_q;

  // Unmapped kseg0/kseg1 reach physical memory by dropping the segment bits
  assign mapped      = (fetch_pc[31:30] != 2'b10);
  assign pa          = mapped ? {s0_pfn, fetch_pc[11:0]} : {3'b000, fetch_pc[28:0]};
  assign icache_addr = pa & FB_MASK;
  assign icache_size = 2'b10;
  assign s0_vpn2     = fetch_pc[31:13];
  assign s0_odd_page = fetch_pc[12];
  assign seq_pc      = (fetch_pc & FB_MASK) + FB_INC;

  assign adel        = |fetch_pc[1:0];
  assign tlb_refill  = ~adel & mapped & ~s0_found;
  assign tlb_invalid = ~adel & mapped & s0_found & ~s0_v;
  assign exc         = adel | tlb_refill | tlb_invalid;

  generate
    if (FETCH_WIDTH == 1) begin : g_single
      assign slot_mask = 1'b1;
    end else begin : g_multi
      localparam int SLOT_W = LOG_FB - 2;
      logic [SLOT_W-1:0] slot_idx;
      assign slot_idx = fetch_pc[LOG_FB-1:2];
      // Slots before the entry word of the block are not part of this fetch
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
        assign slot_mask[gi] = (SLOT_W'(gi) >= slot_idx);
      end
    end
  endgenerate

  assign total    = {1'b0, out_cnt_q} + {1'b0, drop_cnt_q};
  assign go       = ~reset & fs_allowin & (~halted_q | redir);
  assign icache_req = go & ~exc & (total < MAX_TOTAL);
  assign accept   = icache_req & icache_addr_ok;
  assign exc_pass = go & exc;

  assign prefs_to_fs_valid = accept | exc_pass;
  assign prefs_to_fs_bus   = {tlb_refill, tlb_invalid, adel, slot_mask, fetch_pc};

  // Squashed requests are older than any live one, so they return first
  assign drop_nz      = |drop_cnt_q;
  assign stale_ret    = icache_data_ok & drop_nz;
  assign live_ret     = icache_data_ok & ~drop_nz & (|out_cnt_q);
  assign resp_discard = ~reset & stale_ret;

  always_comb begin
    pc_d = pc_q;
    if (accept) begin
      pc_d = seq_pc;
    end else if (redir) begin
      pc_d = redir_target;
    end

    halted_d = halted_q;
    if (exc_pass) begin
      halted_d = 1'b1;
    end else if (redir) begin
      halted_d = 1'b0;
    end

    drop_cnt_d = drop_cnt_q - {3'd0, stale_ret};
    out_cnt_d  = out_cnt_q + {3'd0, accept} - {3'd0, live_ret};
    if (redir) begin
      drop_cnt_d = (total == 5'd0) ? 4'd0 : 4'(total - {4'd0, icache_data_ok});
      out_cnt_d  = {3'd0, accept};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= 4'd0;
      drop_cnt_q <= 4'd0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_preif_pcgen.sv
// Testbench for preif_pcgen: directed scenarios plus a randomized run against
// a queue-based model of in-flight fetches.
module tb_preif_pcgen;

  localparam int          FW    = 2;
  localparam int          MAXO  = 4;
  localparam int          FB    = 4 * FW;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] REF_V  = 32'hbfc00200;
  localparam logic [31:0] EXC_V  = 32'hbfc00380;

  logic              clk = 1'b0;
  logic              reset;
  logic              fs_allowin;
  logic              prefs_to_fs_valid;
  logic [34+FW:0]    prefs_to_fs_bus;
  logic              bp_redirect;
  logic [31:0]       bp_target;
  logic              flush_exc;
  logic              flush_refill;
  logic              flush_eret;
  logic [31:0]       cp0_epc;
  logic              flush_pipe;
  logic [31:0]       flush_pc;
  logic              icache_req;
  logic [1:0]        icache_size;
  logic [31:0]       icache_addr;
  logic              icache_addr_ok;
  logic              icache_data_ok;
  logic              resp_discard;
  logic [18:0]       s0_vpn2;
  logic              s0_odd_page;
  logic              s0_found;
  logic [19:0]       s0_pfn;
  logic              s0_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  preif_pcgen #(
    .RESET_PC(RST_PC), .REFILL_VEC(REF_V), .EXC_VEC(EXC_V),
    .FETCH_WIDTH(FW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .fs_allowin(fs_allowin),
    .prefs_to_fs_valid(prefs_to_fs_valid), .prefs_to_fs_bus(prefs_to_fs_bus),
    .bp_redirect(bp_redirect), .bp_target(bp_target),
    .flush_exc(flush_exc), .flush_refill(flush_refill),
    .flush_eret(flush_eret), .cp0_epc(cp0_epc),
    .flush_pipe(flush_pipe), .flush_pc(flush_pc),
    .icache_req(icache_req), .icache_size(icache_size), .icache_addr(icache_addr),
    .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
    .resp_discard(resp_discard), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page),
    .s0_found(s0_found), .s0_pfn(s0_pfn), .s0_v(s0_v)
  );

  task automatic set_idle();
    reset = 1'b0; fs_allowin = 1'b1;
    bp_redirect = 1'b0; bp_target = 32'd0;
    flush_exc = 1'b0; flush_refill = 1'b0; flush_eret = 1'b0; cp0_epc = 32'd0;
    flush_pipe = 1'b0; flush_pc = 32'd0;
    icache_addr_ok = 1'b1; icache_data_ok = 1'b0;
    s0_found = 1'b1; s0_v = 1'b1; s0_pfn = 20'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1; icache_data_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); #1;
      n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", icache_req); end
      n_vec++; if (prefs_to_fs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", prefs_to_fs_valid); end
      n_vec++; if (resp_discard !== 1'b0) begin n_err++; $display("FAIL reset_discard got %0b want 0", resp_discard); end
    end
    next_cycle();
    reset = 1'b0; icache_data_ok = 1'b0;
    #1;
    n_vec++; if (icache_addr !== 32'h1fc00000) begin n_err++; $display("FAIL reset_addr0 got %h want 1fc00000", icache_addr); end
    n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL reset_req0 got %0b want 1", icache_req); end
    n_vec++; if (prefs_to_fs_bus[33:32] !== 2'b11) begin n_err++; $display("FAIL reset_slot0 got %b want 11", prefs_to_fs_bus[33:32]); end
    n_vec++; if (icache_size !== 2'b10) begin n_err++; $display("FAIL size got %b want 10", icache_size); end
    next_cycle(); #1;
    n_vec++; if (icache_addr !== 32'h1fc00008) begin n_err++; $display("FAIL reset_addr1 got %h want 1fc00008", icache_addr); end
    next_cycle(); #1;
    n_vec++; if (icache_addr !== 32'h1fc00010) begin n_err++; $display("FAIL reset_addr2 got %h want 1fc00010", icache_addr); end
  endtask

  task automatic test_bp_redirect();
    do_reset();
    bp_redirect = 1'b1; bp_target = 32'h80001004;
    #1;
    n_vec++; if (icache_addr !== 32'h00001000) begin n_err++; $display("FAIL bp_addr got %h want 00001000", icache_addr); end
    n_vec++; if (prefs_to_fs_bus[33:32] !== 2'b10) begin n_err++; $display("FAIL bp_slot got %b want 10", prefs_to_fs_bus[33:32]); end
    n_vec++; if (prefs_to_fs_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %0b want 1", prefs_to_fs_valid); end
    next_cycle();
    bp_redirect = 1'b0;
    #1;
    n_vec++; if (prefs_to_fs_bus[31:0] !== 32'h80001008) begin n_err++; $display("FAIL bp_nextpc got %h want 80001008", prefs_to_fs_bus[31:0]); end
    n_vec++; if (prefs_to_fs_bus[33:32] !== 2'b11) begin n_err++; $display("FAIL bp_nextslot got %b want 11", prefs_to_fs_bus[33:32]); end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL max_fill%0d got %0b want 1", c, icache_req); end
      next_cycle();
    end
    #1;
    n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL max_stall got %0b want 0", icache_req); end
    n_vec++; if (prefs_to_fs_valid !== 1'b0) begin n_err++; $display("FAIL max_stall_valid got %0b want 0", prefs_to_fs_valid); end
    next_cycle();
    icache_data_ok = 1'b1;
    #1;
    n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL max_ret_req got %0b want 0", icache_req); end
    n_vec++; if (resp_discard !== 1'b0) begin n_err++; $display("FAIL max_ret_disc got %0b want 0", resp_discard); end
    next_cycle();
    icache_data_ok = 1'b0;
    #1;
    n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL max_resume got %0b want 1", icache_req); end
  endtask

  task automatic test_stale_discard();
    do_reset();
    next_cycle(); next_cycle(); next_cycle();
    flush_pipe = 1'b1; flush_pc = 32'hbfc00100;
    #1;
    n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL stale_req got %0b want 1", icache_req); end
    n_vec++; if (icache_addr !== 32'h1fc00100) begin n_err++; $display("FAIL stale_addr got %h want 1fc00100", icache_addr); end
    next_cycle();
    flush_pipe = 1'b0; fs_allowin = 1'b0; icache_data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (resp_discard !== (c < 3)) begin n_err++; $display("FAIL stale_disc%0d got %0b want %0b", c, resp_discard, (c < 3)); end
      next_cycle();
    end
  endtask

  task automatic test_tlb_refill();
    do_reset();
    bp_redirect = 1'b1; bp_target = 32'h00400000; s0_found = 1'b0;
    #1;
    n_vec++; if (prefs_to_fs_valid !== 1'b1) begin n_err++; $display("FAIL refill_valid got %0b want 1", prefs_to_fs_valid); end
    n_vec++; if (prefs_to_fs_bus[36] !== 1'b1) begin n_err++; $display("FAIL refill_flag got %0b want 1", prefs_to_fs_bus[36]); end
    n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL refill_req got %0b want 0", icache_req); end
    next_cycle();
    bp_redirect = 1'b0;
    #1;
    n_vec++; if (prefs_to_fs_valid !== 1'b0) begin n_err++; $display("FAIL halted_valid got %0b want 0", prefs_to_fs_valid); end
    n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL halted_req got %0b want 0", icache_req); end
    next_cycle();
    flush_exc = 1'b1; flush_refill = 1'b1;
    #1;
    n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL refvec_req got %0b want 1", icache_req); end
    n_vec++; if (icache_addr !== 32'h1fc00200) begin n_err++; $display("FAIL refvec_addr got %h want 1fc00200", icache_addr); end
  endtask

  task automatic test_eret_adel();
    do_reset();
    flush_eret = 1'b1; cp0_epc = 32'hbfc00002;
    #1;
    n_vec++; if (prefs_to_fs_bus[34] !== 1'b1) begin n_err++; $display("FAIL adel_flag got %0b want 1", prefs_to_fs_bus[34]); end
    n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL adel_req got %0b want 0", icache_req); end
    n_vec++; if (prefs_to_fs_valid !== 1'b1) begin n_err++; $display("FAIL adel_valid got %0b want 1", prefs_to_fs_valid); end
    next_cycle();
    flush_eret = 1'b0; flush_exc = 1'b1; bp_redirect = 1'b1; bp_target = 32'h80000040;
    #1;
    n_vec++; if (prefs_to_fs_bus[31:0] !== EXC_V) begin n_err++; $display("FAIL excprio_pc got %h want %h", prefs_to_fs_bus[31:0], EXC_V); end
    n_vec++; if (icache_addr !== 32'h1fc00380) begin n_err++; $display("FAIL excprio_addr got %h want 1fc00380", icache_addr); end
    n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL excprio_req got %0b want 1", icache_req); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 4))
      0: a = 32'hbfc00000 | (a & 32'h0000fffc);
      1: a = 32'h80000000 | (a & 32'h1ffffffc);
      2: a = a & 32'h7ffffffc;
      3: a = 32'hc0000000 | (a & 32'h3ffffffc);
      default: a = 32'hfffffff8;
    endcase
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_random(input int n);
    bit          pend[$];   // one entry per in-flight request; 1 = squashed
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] tgt, fpc, pa, e_addr;
    logic        rd, mapped, adel, refill, inval, exc, go, e_req, acc, e_valid, e_disc;
    logic [FW-1:0]  e_mask;
    logic [34+FW:0] e_bus;
    int idx;
    do_reset();
    m_pc = RST_PC; m_halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      fs_allowin     = ($urandom_range(0, 4) != 0);
      icache_addr_ok = ($urandom_range(0, 2) != 0);
      flush_exc      = ($urandom_range(0, 29) == 0);
      flush_refill   = ($urandom_range(0, 1) == 1);
      flush_eret     = ($urandom_range(0, 29) == 0);
      flush_pipe     = ($urandom_range(0, 19) == 0);
      bp_redirect    = ($urandom_range(0, 11) == 0);
      bp_target = rand_addr(); cp0_epc = rand_addr(); flush_pc = rand_addr();
      s0_found = ($urandom_range(0, 7) != 0);
      s0_v     = ($urandom_range(0, 9) != 0);
      s0_pfn   = 20'($urandom);
      if (pend.size() > 0) icache_data_ok = ($urandom_range(0, 2) == 0);
      else                 icache_data_ok = ($urandom_range(0, 40) == 0);
      #1;
      if (flush_exc && flush_refill) tgt = REF_V;
      else if (flush_exc)            tgt = EXC_V;
      else if (flush_eret)           tgt = cp0_epc;
      else if (flush_pipe)           tgt = flush_pc;
      else                           tgt = bp_target;
      rd     = flush_exc | flush_eret | flush_pipe | bp_redirect;
      fpc    = rd ? tgt : m_pc;
      mapped = (fpc[31:30] != 2'b10);
      pa     = mapped ? {s0_pfn, fpc[11:0]} : (fpc & 32'h1fffffff);
      e_addr = pa - (pa % FB);
      adel   = (fpc % 4) != 0;
      refill = !adel && mapped && !s0_found;
      inval  = !adel && mapped && s0_found && !s0_v;
      exc    = adel || refill || inval;
      idx    = int'((fpc % FB) / 4);
      for (int k = 0; k < FW; k++) e_mask[k] = (k >= idx);
      go      = !reset && fs_allowin && (!m_halt || rd);
      e_req   = go && !exc && (pend.size() < MAXO);
      acc     = e_req && icache_addr_ok;
      e_valid = acc || (go && exc);
      e_disc  = !reset && icache_data_ok && (pend.size() > 0) && pend[0];
      e_bus   = {refill, inval, adel, e_mask, fpc};
      n_vec++; if (icache_req !== e_req) begin n_err++; $display("FAIL rand_req cyc=%0d got %0b want %0b", i, icache_req, e_req); end
      n_vec++; if (icache_addr !== e_addr) begin n_err++; $display("FAIL rand_addr cyc=%0d got %h want %h", i, icache_addr, e_addr); end
      n_vec++; if (prefs_to_fs_valid !== e_valid) begin n_err++; $display("FAIL rand_valid cyc=%0d got %0b want %0b", i, prefs_to_fs_valid, e_valid); end
      n_vec++; if (prefs_to_fs_bus !== e_bus) begin n_err++; $display("FAIL rand_bus cyc=%0d got %h want %h", i, prefs_to_fs_bus, e_bus); end
      n_vec++; if (resp_discard !== e_disc) begin n_err++; $display("FAIL rand_disc cyc=%0d got %0b want %0b", i, resp_discard, e_disc); end
      n_vec++; if ({s0_vpn2, s0_odd_page} !== fpc[31:12]) begin n_err++; $display("FAIL rand_vpn cyc=%0d got %h want %h", i, {s0_vpn2, s0_odd_page}, fpc[31:12]); end
      if (reset) begin
        pend.delete(); m_pc = RST_PC; m_halt = 1'b0;
      end else begin
        if (icache_data_ok && pend.size() > 0) void'(pend.pop_front());
        if (rd) foreach (pend[k]) pend[k] = 1'b1;
        if (acc) pend.push_back(1'b0);
        if (acc)     m_pc = fpc - (fpc % FB) + FB;
        else if (rd) m_pc = tgt;
        if (go && exc) m_halt = 1'b1;
        else if (rd)   m_halt = 1'b0;
      end
      next_cycle();
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_bp_redirect();
    test_max_outstanding();
    test_stale_discard();
    test_tlb_refill();
    test_eret_adel();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
